// File: rtl/decoder_nx2n_seq.sv
// Registered N-to-2^N one-hot decoder with hold, timed-pulse and auto-scan modes and a valid/ready select handshake.
// Latency 1 cycle from accepted select to D; SEL_READY only in IDLE/HOLD with E high. Macro DEC_OUT_ACTIVE_LOW_EN makes D active-low.
module decoder_nx2n_seq #(
    parameter int N          = 2,
    parameter int PULSE_LEN  = 2,
    parameter int SCAN_DWELL = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                E,
    input  logic [1:0]          MODE,
    input  logic [N-1:0]        SEL,
    input  logic                SEL_VALID,
    output logic                SEL_READY,
    output logic [(1<<N)-1:0]   D,
    output logic                BUSY
);

    localparam int W   = 1 << N;
    localparam int PCW = (PULSE_LEN  > 1) ? $clog2(PULSE_LEN)  : 1;
    localparam int DCW = (SCAN_DWELL > 1) ? $clog2(SCAN_DWELL) : 1;
    localparam logic [PCW-1:0] PCNT_INIT  = PCW'(PULSE_LEN - 1);
    localparam logic [DCW-1:0] DWELL_INIT = DCW'(SCAN_DWELL - 1);

`ifdef DEC_OUT_ACTIVE_LOW_EN
    localparam logic [W-1:0] D_POL = '1;
`else
    localparam logic [W-1:0] D_POL = '0;
`endif

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_HOLD  = 2'd1,
        ST_PULSE = 2'd2,
        ST_SCAN  = 2'd3
    } state_t;

    state_t         r_state;
    logic [W-1:0]   r_d;
    logic [PCW-1:0] r_pcnt;
    logic [N-1:0]   r_idx;
    logic [DCW-1:0] r_dwell;
    logic           r_live;
    logic           r_busy;

    state_t         w_state_nxt;
    logic [W-1:0]   w_d_hi_nxt;
    logic [PCW-1:0] w_pcnt_nxt;
    logic [N-1:0]   w_idx_nxt;
    logic [DCW-1:0] w_dwell_nxt;
    logic           w_accept;
    logic           w_mode_scan;

    // r_live keeps READY low during reset and for the first cycle after it
    assign SEL_READY   = E & r_live & ((r_state == ST_IDLE) | (r_state == ST_HOLD));
    assign w_accept    = SEL_VALID & SEL_READY;
    assign w_mode_scan = (MODE == 2'b10);
    assign D           = r_d;
    assign BUSY        = r_busy;

    always_comb begin
        w_state_nxt = r_state;
        w_d_hi_nxt  = r_d ^ D_POL;
        w_pcnt_nxt  = r_pcnt;
        w_idx_nxt   = r_idx;
        w_dwell_nxt = r_dwell;

        if (!E) begin
            w_state_nxt = ST_IDLE;
            w_d_hi_nxt  = '0;
            w_pcnt_nxt  = '0;
            w_idx_nxt   = '0;
            w_dwell_nxt = '0;
        end else begin
            case (r_state)
                ST_IDLE, ST_HOLD: begin
                    // Scan entry takes priority over a pending select
                    if (w_mode_scan) begin
                        w_state_nxt = ST_SCAN;
                        w_idx_nxt   = '0;
                        w_d_hi_nxt  = W'(1);
                        w_dwell_nxt = DWELL_INIT;
                    end else if (w_accept) begin
                        w_d_hi_nxt = W'(1) << SEL;
                        if (MODE == 2'b01) begin
                            w_state_nxt = ST_PULSE;
                            w_pcnt_nxt  = PCNT_INIT;
                        end else begin
                            w_state_nxt = ST_HOLD;
                        end
                    end
                end
                ST_PULSE: begin
                    if (r_pcnt == '0) begin
                        w_state_nxt = ST_IDLE;
                        w_d_hi_nxt  = '0;
                    end else begin
                        w_pcnt_nxt = r_pcnt - PCW'(1);
                    end
                end
                ST_SCAN: begin
                    if (!w_mode_scan) begin
                        w_state_nxt = ST_IDLE;
                        w_d_hi_nxt  = '0;
                        w_idx_nxt   = '0;
                        w_dwell_nxt = '0;
                    end else if (r_dwell == '0) begin
                        w_idx_nxt   = r_idx + N'(1);
                        w_d_hi_nxt  = W'(1) << w_idx_nxt;
                        w_dwell_nxt = DWELL_INIT;
                    end else begin
                        w_dwell_nxt = r_dwell - DCW'(1);
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                    w_d_hi_nxt  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_d     <= D_POL;
            r_pcnt  <= '0;
            r_idx   <= '0;
            r_dwell <= '0;
            r_live  <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_d     <= w_d_hi_nxt ^ D_POL;
            r_pcnt  <= w_pcnt_nxt;
            r_idx   <= w_idx_nxt;
            r_dwell <= w_dwell_nxt;
            r_live  <= 1'b1;
            r_busy  <= (w_state_nxt == ST_PULSE) | (w_state_nxt == ST_SCAN);
        end
    end

endmodule

// File: tb/tb_decoder_nx2n_seq.sv
// Directed checks on a N=2 decoder plus a reference-model soak on a N=3 instance.
module tb_decoder_nx2n_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Instance A: N=2, PULSE_LEN=3, SCAN_DWELL=2
    logic       a_rst, a_e, a_vld, a_rdy, a_busy;
    logic [1:0] a_mode, a_sel;
    logic [3:0] a_d;

    decoder_nx2n_seq #(.N(2), .PULSE_LEN(3), .SCAN_DWELL(2)) u_a (
        .clk(clk), .rst(a_rst), .E(a_e), .MODE(a_mode), .SEL(a_sel),
        .SEL_VALID(a_vld), .SEL_READY(a_rdy), .D(a_d), .BUSY(a_busy)
    );

    // Instance B: N=3, PULSE_LEN=4, SCAN_DWELL=3
    logic       b_rst, b_e, b_vld, b_rdy, b_busy;
    logic [1:0] b_mode;
    logic [2:0] b_sel;
    logic [7:0] b_d;

    decoder_nx2n_seq #(.N(3), .PULSE_LEN(4), .SCAN_DWELL(3)) u_b (
        .clk(clk), .rst(b_rst), .E(b_e), .MODE(b_mode), .SEL(b_sel),
        .SEL_VALID(b_vld), .SEL_READY(b_rdy), .D(b_d), .BUSY(b_busy)
    );

    task automatic exp_a(input string tag, input logic [3:0] d, input logic busy, input logic rdy);
        chk({tag, ".d"}, 64'(a_d), 64'(d));
        chk({tag, ".busy"}, 64'(a_busy), 64'(busy));
        chk({tag, ".rdy"}, 64'(a_rdy), 64'(rdy));
    endtask

    // Reference model for instance B (0 idle, 1 hold, 2 pulse, 3 scan)
    int         m_st, m_pc, m_idx, m_dw;
    logic       m_live;
    logic [7:0] m_d;

    task automatic model_b();
        logic rdy_now;
        rdy_now = b_e && m_live && (m_st <= 1);
        if (b_rst) begin
            m_st = 0; m_d = 8'h00; m_pc = 0; m_idx = 0; m_dw = 0; m_live = 1'b0;
        end else begin
            m_live = 1'b1;
            if (!b_e) begin
                m_st = 0; m_d = 8'h00; m_pc = 0; m_idx = 0; m_dw = 0;
            end else if (m_st <= 1) begin
                if (b_mode == 2'b10) begin
                    m_st = 3; m_idx = 0; m_d = 8'h01; m_dw = 2;
                end else if (b_vld && rdy_now) begin
                    m_d = 8'h01 << b_sel;
                    if (b_mode == 2'b01) begin
                        m_st = 2; m_pc = 3;
                    end else begin
                        m_st = 1;
                    end
                end
            end else if (m_st == 2) begin
                if (m_pc == 0) begin
                    m_st = 0; m_d = 8'h00;
                end else begin
                    m_pc--;
                end
            end else begin
                if (b_mode != 2'b10) begin
                    m_st = 0; m_d = 8'h00; m_idx = 0; m_dw = 0;
                end else if (m_dw == 0) begin
                    m_idx = (m_idx + 1) % 8;
                    m_d   = 8'h01 << m_idx;
                    m_dw  = 2;
                end else begin
                    m_dw--;
                end
            end
        end
    endtask

    logic [3:0] scan_seq [9];

    initial begin
        scan_seq = '{4'b0001, 4'b0001, 4'b0010, 4'b0010, 4'b0100,
                     4'b0100, 4'b1000, 4'b1000, 4'b0001};
        b_rst = 1'b1; b_e = 1'b0; b_mode = 2'b00; b_sel = 3'd0; b_vld = 1'b0;

        // Reset with random inputs
        a_rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            a_e = 1'($urandom); a_mode = 2'($urandom); a_sel = 2'($urandom); a_vld = 1'($urandom);
            tick();
            exp_a("reset", 4'b0000, 1'b0, 1'b0);
        end
        a_rst = 1'b0; a_e = 1'b1; a_mode = 2'b00; a_vld = 1'b0; a_sel = 2'd0;
        #1 chk("rdy_first_cycle", 64'(a_rdy), 64'd0);
        tick();
        exp_a("rdy_after_release", 4'b0000, 1'b0, 1'b1);

        // Hold mode
        a_sel = 2'd2; a_vld = 1'b1;
        tick(); exp_a("hold_sel2", 4'b0100, 1'b0, 1'b1);
        a_vld = 1'b0;
        tick(); exp_a("hold_keep", 4'b0100, 1'b0, 1'b1);
        a_sel = 2'd3; a_vld = 1'b1;
        tick(); exp_a("hold_sel3", 4'b1000, 1'b0, 1'b1);
        a_vld = 1'b0; a_e = 1'b0;
        tick(); exp_a("hold_e_low", 4'b0000, 1'b0, 1'b0);
        a_e = 1'b1;

        // Pulse mode: exactly 3 cycles, mid-pulse select ignored
        a_mode = 2'b01; a_sel = 2'd1; a_vld = 1'b1;
        tick(); exp_a("pulse_c1", 4'b0010, 1'b1, 1'b0);
        a_vld = 1'b0;
        tick(); exp_a("pulse_c2", 4'b0010, 1'b1, 1'b0);
        a_vld = 1'b1; a_sel = 2'd3;
        tick(); exp_a("pulse_c3", 4'b0010, 1'b1, 1'b0);
        a_vld = 1'b0;
        tick(); exp_a("pulse_end", 4'b0000, 1'b0, 1'b1);
        tick(); exp_a("pulse_idle", 4'b0000, 1'b0, 1'b1);

        // Scan with wrap, then exit
        a_mode = 2'b10;
        for (int i = 0; i < 9; i++) begin
            tick();
            exp_a($sformatf("scan_%0d", i), scan_seq[i], 1'b1, 1'b0);
        end
        a_mode = 2'b00;
        tick(); exp_a("scan_exit", 4'b0000, 1'b0, 1'b1);

        // Abort pulse with E low, no residual pulse after re-enable
        a_mode = 2'b01; a_sel = 2'd1; a_vld = 1'b1;
        tick(); exp_a("abort_pulse_start", 4'b0010, 1'b1, 1'b0);
        a_vld = 1'b0; a_e = 1'b0;
        tick(); exp_a("abort_e_low", 4'b0000, 1'b0, 1'b0);
        a_e = 1'b1;
        tick(); exp_a("abort_reen1", 4'b0000, 1'b0, 1'b1);
        tick(); exp_a("abort_reen2", 4'b0000, 1'b0, 1'b1);

        // rst mid-scan
        a_mode = 2'b10;
        tick(); exp_a("rst_scan_start", 4'b0001, 1'b1, 1'b0);
        tick(); exp_a("rst_scan_dwell", 4'b0001, 1'b1, 1'b0);
        a_rst = 1'b1;
        tick(); exp_a("rst_in_scan", 4'b0000, 1'b0, 1'b0);
        a_rst = 1'b0; a_mode = 2'b00;
        tick(); exp_a("rst_scan_release", 4'b0000, 1'b0, 1'b1);

        // E low with a select presented: dropped
        a_e = 1'b0; a_vld = 1'b1; a_sel = 2'd2;
        tick(); exp_a("e_low_drop", 4'b0000, 1'b0, 1'b0);
        a_e = 1'b1; a_vld = 1'b0;
        tick(); exp_a("e_low_after", 4'b0000, 1'b0, 1'b1);

        // Scan beats a simultaneous select
        a_mode = 2'b10; a_vld = 1'b1; a_sel = 2'd3;
        tick(); exp_a("scan_wins", 4'b0001, 1'b1, 1'b0);
        a_mode = 2'b00; a_vld = 1'b0;
        tick(); exp_a("scan_wins_exit", 4'b0000, 1'b0, 1'b1);

        // Reference-model soak on instance B
        m_st = 0; m_d = 8'h00; m_pc = 0; m_idx = 0; m_dw = 0; m_live = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            b_rst = (i < 2) || ($urandom_range(0, 99) == 0);
            b_e   = ($urandom_range(0, 19) != 0);
            if ($urandom_range(0, 7) == 0) b_mode = 2'($urandom);
            b_sel = 3'($urandom);
            b_vld = 1'($urandom);
            #1 chk("soak.rdy", 64'(b_rdy), 64'(b_e && m_live && (m_st <= 1)));
            model_b();
            tick();
            chk("soak.d", 64'(b_d), 64'(m_d));
            chk("soak.busy", 64'(b_busy), 64'(m_st >= 2));
            chk("soak.onehot0", 64'($onehot0(b_d)), 64'd1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
